// File: rtl/decode_stage.sv
// Registered RV32I decode stage with valid/ready handshake, flush and a handshake counter.
// Optional RV32M multiply decode is enabled by defining DECODE_MEXT_EN.
module decode_stage #(
   parameter int XLEN     = 32,
   parameter int ALUCTL_W = 4,
   parameter int CNT_W    = 16
) (
   input  logic                i_Clk,
   input  logic                i_Rst_n,
   input  logic [31:0]         i_Instr,
   input  logic                i_Valid,
   output logic                o_Ready,
   input  logic                i_Flush,
   output logic                o_Valid,
   input  logic                i_Ready,
   output logic [ALUCTL_W-1:0] o_ALUctl,
   output logic                o_Branch,
   output logic                o_MemToReg,
   output logic                o_MemWrite,
   output logic                o_ALUsrc,
   output logic                o_RegWrite,
   output logic                o_Illegal,
   output logic [4:0]          o_Rd,
   output logic [4:0]          o_Rs1,
   output logic [4:0]          o_Rs2,
   output logic [XLEN-1:0]     o_Imm,
   output logic [CNT_W-1:0]    o_DecodeCnt
);

   localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3;
   localparam logic [3:0] ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7;
   localparam logic [3:0] ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   // Shared R/I ALU mapping; alt selects SUB/SRA on funct3 0/5.
   function automatic logic [3:0] f_alu_op(input logic [2:0] f3, input logic alt);
      logic [3:0] op;
      case (f3)
         3'd0:    op = alt ? ALU_SUB : ALU_ADD;
         3'd1:    op = ALU_SLL;
         3'd2:    op = ALU_SLT;
         3'd3:    op = ALU_SLTU;
         3'd4:    op = ALU_XOR;
         3'd5:    op = alt ? ALU_SRA : ALU_SRL;
         3'd6:    op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

   logic [6:0]         w_opcode;
   logic [2:0]         w_funct3;
   logic [6:0]         w_funct7;
   logic [3:0]         w_alu;
   logic               w_branch, w_memtoreg, w_memwrite, w_alusrc, w_regwrite, w_illegal;
   logic signed [31:0] w_imm;
   logic               w_load, w_unload;

   logic               r_Valid;
   logic [CNT_W-1:0]   r_DecodeCnt;

   assign w_opcode = i_Instr[6:0];
   assign w_funct3 = i_Instr[14:12];
   assign w_funct7 = i_Instr[31:25];

   always_comb begin
      w_alu      = ALU_ADD;
      w_branch   = 1'b0;
      w_memtoreg = 1'b0;
      w_memwrite = 1'b0;
      w_alusrc   = 1'b0;
      w_regwrite = 1'b0;
      w_illegal  = 1'b0;
      w_imm      = '0;
      case (w_opcode)
         OP_R: begin
            w_regwrite = 1'b1;
            if (w_funct7 == 7'h00 ||
                (w_funct7 == 7'h20 && (w_funct3 == 3'd0 || w_funct3 == 3'd5)))
               w_alu = f_alu_op(w_funct3, w_funct7[5]);
`ifdef DECODE_MEXT_EN
            else if (w_funct7 == 7'h01 && !w_funct3[2])
               w_alu = 4'd11 + {2'b00, w_funct3[1:0]};
`endif
            else
               w_illegal = 1'b1;
         end
         OP_IMM: begin
            w_alusrc   = 1'b1;
            w_regwrite = 1'b1;
            w_alu      = f_alu_op(w_funct3, (w_funct3 == 3'd5) & i_Instr[30]);
            w_imm      = signed'({{20{i_Instr[31]}}, i_Instr[31:20]});
         end
         OP_LOAD: begin
            w_alusrc   = 1'b1;
            w_memtoreg = 1'b1;
            w_regwrite = 1'b1;
            w_imm      = signed'({{20{i_Instr[31]}}, i_Instr[31:20]});
         end
         OP_STORE: begin
            w_alusrc   = 1'b1;
            w_memwrite = 1'b1;
            w_imm      = signed'({{20{i_Instr[31]}}, i_Instr[31:25], i_Instr[11:7]});
         end
         OP_BRANCH: begin
            w_branch = 1'b1;
            w_alu    = ALU_SUB;
            w_imm    = signed'({{19{i_Instr[31]}}, i_Instr[31], i_Instr[7],
                                i_Instr[30:25], i_Instr[11:8], 1'b0});
         end
         OP_LUI: begin
            w_regwrite = 1'b1;
            w_alu      = ALU_PASSB;
            w_imm      = signed'({i_Instr[31:12], 12'b0});
         end
         OP_AUIPC: begin
            w_regwrite = 1'b1;
            w_imm      = signed'({i_Instr[31:12], 12'b0});
         end
         OP_JAL: begin
            w_regwrite = 1'b1;
            w_imm      = signed'({{11{i_Instr[31]}}, i_Instr[31], i_Instr[19:12],
                                  i_Instr[20], i_Instr[30:21], 1'b0});
         end
         OP_JALR: begin
            w_regwrite = 1'b1;
            w_imm      = signed'({{20{i_Instr[31]}}, i_Instr[31:20]});
         end
         default: w_illegal = 1'b1;
      endcase
      // Illegal words must not change architectural state downstream.
      if (w_illegal) begin
         w_branch   = 1'b0;
         w_memwrite = 1'b0;
         w_regwrite = 1'b0;
         w_alu      = ALU_ADD;
      end
   end

   assign o_Ready     = !r_Valid | i_Ready;
   assign o_Valid     = r_Valid;
   assign o_DecodeCnt = r_DecodeCnt;
   assign w_load      = i_Valid & o_Ready;
   assign w_unload    = r_Valid & i_Ready;

   // Output pipeline register toward execute
   always_ff @(posedge i_Clk) begin
      if (!i_Rst_n) begin
         r_Valid     <= 1'b0;
         r_DecodeCnt <= '0;
         o_ALUctl    <= '0;
         o_Branch    <= 1'b0;
         o_MemToReg  <= 1'b0;
         o_MemWrite  <= 1'b0;
         o_ALUsrc    <= 1'b0;
         o_RegWrite  <= 1'b0;
         o_Illegal   <= 1'b0;
         o_Rd        <= '0;
         o_Rs1       <= '0;
         o_Rs2       <= '0;
         o_Imm       <= '0;
      end else begin
         if (w_unload && !i_Flush)
            r_DecodeCnt <= r_DecodeCnt + CNT_W'(1);
         if (i_Flush) begin
            r_Valid <= 1'b0;
         end else if (w_load) begin
            r_Valid    <= 1'b1;
            o_ALUctl   <= ALUCTL_W'(w_alu);
            o_Branch   <= w_branch;
            o_MemToReg <= w_memtoreg;
            o_MemWrite <= w_memwrite;
            o_ALUsrc   <= w_alusrc;
            o_RegWrite <= w_regwrite;
            o_Illegal  <= w_illegal;
            o_Rd       <= i_Instr[11:7];
            o_Rs1      <= i_Instr[19:15];
            o_Rs2      <= i_Instr[24:20];
            o_Imm      <= XLEN'(w_imm);
         end else if (w_unload) begin
            r_Valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Randomized bench for decode_stage: a transaction-level reference model is compared
// against the DUT every cycle, plus directed literal checks that pin the model.
module tb_decode_stage;

   localparam int XLEN = 32;
   localparam int ALUCTL_W = 4;
   localparam int CNT_W = 4;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [31:0]         instr = '0;
   logic                in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
   logic                o_ready, o_valid;
   logic [ALUCTL_W-1:0] alu;
   logic                br, m2r, mw, asrc, rw, ill;
   logic [4:0]          rd, rs1, rs2;
   logic [XLEN-1:0]     imm;
   logic [CNT_W-1:0]    cnt;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_on = 1'b0;

   decode_stage #(.XLEN(XLEN), .ALUCTL_W(ALUCTL_W), .CNT_W(CNT_W)) dut (
      .i_Clk(clk), .i_Rst_n(rst_n), .i_Instr(instr), .i_Valid(in_valid), .o_Ready(o_ready),
      .i_Flush(flush), .o_Valid(o_valid), .i_Ready(out_ready), .o_ALUctl(alu),
      .o_Branch(br), .o_MemToReg(m2r), .o_MemWrite(mw), .o_ALUsrc(asrc), .o_RegWrite(rw),
      .o_Illegal(ill), .o_Rd(rd), .o_Rs1(rs1), .o_Rs2(rs2), .o_Imm(imm), .o_DecodeCnt(cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [3:0]  alu;
      logic        br, m2r, mw, asrc, rw, ill;
      logic [14:0] regs;
      logic [31:0] imm;
   } pl_t;

   function automatic pl_t ref_decode(input logic [31:0] w);
      pl_t p;
      int  f3, f7;
      int  base_alu [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
      f3 = int'(w[14:12]);
      f7 = int'(w[31:25]);
      p = '0;
      p.regs = {w[11:7], w[19:15], w[24:20]};
      case (w[6:0])
         7'h33: begin
            if (f7 == 0) begin p.alu = 4'(base_alu[f3]); p.rw = 1; end
            else if (f7 == 32 && (f3 == 0 || f3 == 5)) begin p.alu = 4'(base_alu[f3] + 1); p.rw = 1; end
`ifdef DECODE_MEXT_EN
            else if (f7 == 1 && f3 < 4) begin p.alu = 4'(11 + f3); p.rw = 1; end
`endif
            else p.ill = 1;
         end
         7'h13: begin
            p.alu = 4'(base_alu[f3] + ((f3 == 5 && w[30]) ? 1 : 0));
            p.asrc = 1; p.rw = 1; p.imm = $signed(w) >>> 20;
         end
         7'h03: begin p.asrc = 1; p.m2r = 1; p.rw = 1; p.imm = $signed(w) >>> 20; end
         7'h23: begin p.asrc = 1; p.mw = 1; p.imm = $signed({w[31:25], w[11:7], 20'b0}) >>> 20; end
         7'h63: begin p.br = 1; p.alu = 1; p.imm = $signed({w[31], w[7], w[30:25], w[11:8], 20'b0}) >>> 19; end
         7'h37: begin p.rw = 1; p.alu = 10; p.imm = {w[31:12], 12'b0}; end
         7'h17: begin p.rw = 1; p.imm = {w[31:12], 12'b0}; end
         7'h6F: begin p.rw = 1; p.imm = $signed({w[31], w[19:12], w[20], w[30:21], 12'b0}) >>> 11; end
         7'h67: begin p.rw = 1; p.imm = $signed(w) >>> 20; end
         default: p.ill = 1;
      endcase
      return p;
   endfunction

   bit          m_valid = 1'b0;
   int          m_cnt = 0;
   pl_t         m_pl = '0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_valid = 1'b0; m_cnt = 0; m_pl = '0;
      end else begin
         bit accept;
         accept = in_valid && (!m_valid || out_ready);
         if (m_valid && out_ready && !flush) m_cnt = (m_cnt + 1) % (1 << CNT_W);
         if (flush) m_valid = 1'b0;
         else if (accept) begin m_valid = 1'b1; m_pl = ref_decode(instr); end
         else if (out_ready) m_valid = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("valid", o_valid, m_valid);
         chk("ready", o_ready, !m_valid || out_ready);
         chk("count", cnt, m_cnt);
         if (m_valid) begin
            chk("ctl", {alu, br, m2r, mw, asrc, rw, ill},
                {m_pl.alu, m_pl.br, m_pl.m2r, m_pl.mw, m_pl.asrc, m_pl.rw, m_pl.ill});
            chk("regs", {rd, rs1, rs2}, m_pl.regs);
            chk("imm", imm, m_pl.imm);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      logic [6:0]  ops [10];
      logic [6:0]  f7s [3];
      ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h33};
      f7s = '{7'h00, 7'h20, 7'h01};
      w = $urandom;
      if ($urandom_range(0, 7) != 0) w[6:0] = ops[$urandom_range(0, 9)];
      if ($urandom_range(0, 3) != 0) w[31:25] = f7s[$urandom_range(0, 2)];
      return w;
   endfunction

   initial begin
      tick(); tick();
      chk_on = 1'b1;
      rst_n = 1'b1;
      #1;
      chk("rst_valid", o_valid, 0);
      chk("rst_ready", o_ready, 1);
      chk("rst_cnt", cnt, 0);
      chk("rst_alu_imm", {alu, imm}, 0);

      // add: fields come straight from the word
      instr = 32'h001100B3; in_valid = 1; out_ready = 1;
      tick();
      in_valid = 0;
      chk("add_valid", o_valid, 1);
      chk("add_ctl", {alu, rw, asrc}, {4'd0, 1'b1, 1'b0});
      chk("add_regs", {rd, rs1, rs2}, {5'd1, 5'd2, 5'd1});
      tick();
      chk("add_cnt", cnt, 1);

      // addi held under back-pressure, then sb
      instr = 32'hFFF00093; in_valid = 1; out_ready = 1;
      tick();
      instr = 32'h00208023; out_ready = 0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("hold_imm", imm, 32'hFFFF_FFFF);
         chk("hold_asrc", asrc, 1);
         chk("hold_ready", o_ready, 0);
         tick();
      end
      out_ready = 1;
      tick();
      in_valid = 0;
      chk("sb_ctl", {o_valid, mw, rw}, 3'b110);
      chk("sb_imm", imm, 0);
      tick();
      chk("sb_cnt", cnt, 3);

      // flush beats a concurrent load and does not count
      instr = 32'hFFF00093; in_valid = 1; out_ready = 0;
      tick();
      instr = 32'h00208023; flush = 1;
      tick();
      flush = 0; in_valid = 0;
      chk("flush_valid", o_valid, 0);
      chk("flush_cnt", cnt, 3);

      // mul
      instr = 32'h02208033; in_valid = 1; out_ready = 1;
      tick();
      in_valid = 0;
`ifdef DECODE_MEXT_EN
      chk("mul_ctl", {alu, ill, rw}, {4'd11, 1'b0, 1'b1});
`else
      chk("mul_ctl", {alu, ill, rw}, {4'd0, 1'b1, 1'b0});
`endif
      tick();
      chk("mul_cnt", cnt, 4);

      // full-rate stream up to counter wrap
      instr = 32'h00500113; in_valid = 1; out_ready = 1;
      repeat (12) tick();
      chk("cnt_max", cnt, 4'hF);
      tick();
      chk("cnt_wrap", cnt, 0);
      out_ready = 0;
      tick();
      rst_n = 0;
      tick();
      chk("rst_hold_valid", o_valid, 0);
      rst_n = 1; in_valid = 0;
      tick();

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         instr     = rand_instr();
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 15) == 0);
         rst_n     = ($urandom_range(0, 199) != 0);
         tick();
      end
      rst_n = 1; flush = 0; in_valid = 0;
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
